// File: rtl/ysyx_24100012_inst_fetch_pkg.sv
// ysyx_24100012_inst_fetch_pkg: shared FSM encoding and fetch constants
package ysyx_24100012_inst_fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} ifu_state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/ysyx_24100012_inst_fetch.sv
// ysyx_24100012_inst_fetch: single-outstanding instruction fetch with redirect and wrong-path discard
module ysyx_24100012_inst_fetch
  import ysyx_24100012_inst_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  output logic                  imem_rsp_ready,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_fault,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);
  ifu_state_e state, state_d;
  logic [ADDR_WIDTH-1:0] req_addr, req_addr_d, pc_next, pc_next_d, pc_d, launch_addr;
  logic [DATA_WIDTH-1:0] instr_d;
  logic discard, discard_d, fault_d, launch;
  assign imem_req_valid = state == REQ;
  assign imem_req_addr  = imem_req_valid ? req_addr : '0;
  assign imem_rsp_ready = state == WAIT;
  assign inst_valid     = state == HOLD;
  // Next state: a "launch" starts a new fetch, or raises a fault directly when the target is misaligned
  always_comb begin
    state_d     = state;
    req_addr_d  = req_addr;
    pc_next_d   = pc_next;
    discard_d   = discard;
    instr_d     = instruction;
    pc_d        = inst_pc;
    fault_d     = inst_fault;
    launch      = 1'b0;
    launch_addr = req_addr;
    case (state)
      IDLE: begin
        launch      = 1'b1;
        launch_addr = redirect_valid ? redirect_pc : req_addr;
      end
      REQ: begin
        if (redirect_valid) begin
          discard_d = 1'b1;
          pc_next_d = redirect_pc;
        end
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid && (redirect_valid || discard)) begin
          launch      = 1'b1;
          launch_addr = redirect_valid ? redirect_pc : pc_next;
          discard_d   = 1'b0;
        end else if (imem_rsp_valid) begin
          state_d = HOLD;
          instr_d = imem_rsp_err ? DATA_WIDTH'(NOP) : imem_rsp_data;
          pc_d    = req_addr;
          fault_d = imem_rsp_err;
        end else if (redirect_valid) begin
          discard_d = 1'b1;
          pc_next_d = redirect_pc;
        end
      end
      HOLD: begin
        launch      = redirect_valid || inst_ready;
        launch_addr = redirect_valid ? redirect_pc : inst_pc + ADDR_WIDTH'(PC_INC);
      end
      default: ;
    endcase
    if (launch) begin
      req_addr_d = launch_addr;
      state_d    = |launch_addr[1:0] ? HOLD : REQ;
      if (|launch_addr[1:0]) begin
        instr_d = DATA_WIDTH'(NOP);
        pc_d    = launch_addr;
        fault_d = 1'b1;
      end
    end
  end
  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_addr    <= RESET_PC;
      pc_next     <= RESET_PC;
      discard     <= 1'b0;
      instruction <= '0;
      inst_pc     <= '0;
      inst_fault  <= 1'b0;
    end else begin
      state       <= state_d;
      req_addr    <= req_addr_d;
      pc_next     <= pc_next_d;
      discard     <= discard_d;
      instruction <= instr_d;
      inst_pc     <= pc_d;
      inst_fault  <= fault_d;
    end
  end
endmodule

// File: tb/tb_ysyx_24100012_inst_fetch.sv
// tb_ysyx_24100012_inst_fetch: randomized memory/decode/redirect bench against a program-order reference model
module tb_ysyx_24100012_inst_fetch;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0, imem_rsp_ready, imem_rsp_err = 1'b0;
  logic inst_valid, inst_ready = 1'b0, inst_fault, redirect_valid = 1'b0;
  logic [31:0] imem_req_addr, imem_rsp_data = '0, instruction, inst_pc, redirect_pc = '0;
  int n_cmp = 0, n_err = 0, cyc = 0, n_rqv = 0, n_iv = 0, lat_cnt = 0, lat_max = 0, irdy = 1;
  bit outstanding = 0, lat_fix = 1, rdy_rand = 0, rd_rand = 0, fresh = 1;
  logic [31:0] mem_addr, exp_pc = 32'h8000_0000;
  logic p_req_valid, p_rsp_ready, p_inst_valid;
  logic [31:0] p_req_addr, p_inst_pc, p_instr;
  logic [31:0] acc_q[$], hs_pc[$], hs_ins[$];
  int hs_cyc[$];
  int a, n0;
  logic [31:0] pc0;

  ysyx_24100012_inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] ad);
    return ad == 32'h8000_0000 ? 32'h0010_0093 : (ad * 32'h9E37_79B1) ^ 32'h0000_0a03;
  endfunction
  function automatic bit err_of(input logic [31:0] ad);
    return ad[7:0] == 8'h08;
  endfunction
  function automatic bit exp_fault(input logic [31:0] ad);
    return ad[1:0] != 2'b00 || err_of(ad);
  endfunction
  function automatic logic [31:0] rand_target();
    int k = int'($urandom_range(0, 15));
    logic [31:0] t = 32'h8000_0000 + 32'($urandom_range(0, 255) << 2);
    if (k == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) << 2);
    if (k == 1) t = t + 32'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (p_rsp_ready && imem_rsp_valid) begin
      outstanding = 0;
      imem_rsp_valid = 1'b0;
    end
    if (p_req_valid && imem_req_ready) begin
      chk("one_outstanding", 32'(outstanding), 32'd0);
      outstanding = 1;
      mem_addr = p_req_addr;
      lat_cnt = lat_fix ? lat_max : int'($urandom_range(0, lat_max));
      acc_q.push_back(p_req_addr);
    end
    if (p_req_valid && !imem_req_ready) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, p_req_addr);
    end
    if (redirect_valid) begin
      exp_pc = redirect_pc;
      fresh = 1;
    end else if (p_inst_valid && inst_ready) begin
      exp_pc = p_inst_pc + 32'd4;
      fresh = 1;
      hs_cyc.push_back(cyc);
      hs_pc.push_back(p_inst_pc);
      hs_ins.push_back(p_instr);
    end
    chk("rsp_ready", 32'(imem_rsp_ready), 32'(outstanding));
    if (imem_req_valid) begin
      n_rqv++;
      chk("req_align", 32'(imem_req_addr[1:0]), 32'd0);
    end
    if (inst_valid) begin
      n_iv++;
      if (fresh) begin
        chk("inst_pc", inst_pc, exp_pc);
        fresh = 0;
      end else begin
        chk("inst_spurious", 32'(p_inst_valid), 32'd1);
        chk("inst_pc_stable", inst_pc, p_inst_pc);
      end
      chk("instruction", instruction, exp_fault(inst_pc) ? 32'h0000_0013 : data_of(inst_pc));
      chk("inst_fault", 32'(inst_fault), 32'(exp_fault(inst_pc)));
    end
    p_req_valid = imem_req_valid;
    p_req_addr = imem_req_addr;
    p_rsp_ready = imem_rsp_ready;
    p_inst_valid = inst_valid;
    p_inst_pc = inst_pc;
    p_instr = instruction;
    imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    inst_ready = (irdy == 2) ? 1'($urandom_range(0, 1)) : (irdy == 1);
    redirect_valid = rd_rand && ($urandom_range(0, 19) == 0);
    redirect_pc = rand_target();
    if (outstanding && !imem_rsp_valid) begin
      if (lat_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = data_of(mem_addr);
        imem_rsp_err = err_of(mem_addr);
      end else lat_cnt--;
    end
    if (!imem_rsp_valid) begin
      imem_rsp_data = $urandom;
      imem_rsp_err = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);
    chk("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_fault", 32'(inst_fault), 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    outstanding = 0;
    exp_pc = 32'h8000_0000;
    fresh = 1;
    p_req_valid = 1'b0;
    p_rsp_ready = 1'b0;
    p_inst_valid = 1'b0;
    p_req_addr = '0;
    p_inst_pc = '0;
    p_instr = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit cond(input int kind, input logic [31:0] v);
    case (kind)
      0: return inst_valid;
      1: return inst_valid && inst_pc == v;
      2: return imem_rsp_ready;
      3: return acc_q.size() >= int'(v);
      default: return hs_cyc.size() >= int'(v);
    endcase
  endfunction

  task automatic wait_for(input int kind, input logic [31:0] v, input string tag);
    for (int i = 0; i < 300; i++) begin
      if (cond(kind, v)) return;
      cycle();
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout, got no event expected event within 300 cycles", tag);
  endtask

  initial begin
    do_reset();
    wait_for(4, 32'd2, "a_handshakes");
    chk("a_first_req", acc_q[0], 32'h8000_0000);
    chk("a_second_req", acc_q[1], 32'h8000_0004);
    chk("a_first_pc", hs_pc[0], 32'h8000_0000);
    chk("a_first_ins", hs_ins[0], 32'h0010_0093);
    chk("a_ipc_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
    irdy = 0;
    inst_ready = 1'b0;
    wait_for(0, 32'd0, "b_valid");
    pc0 = inst_pc;
    n0 = n_rqv;
    repeat (5) cycle();
    chk("b_no_req", 32'(n_rqv - n0), 32'd0);
    chk("b_pc_stable", inst_pc, pc0);
    irdy = 1;
    inst_ready = 1'b1;
    a = acc_q.size();
    wait_for(3, 32'(a + 1), "b_next_req");
    chk("b_next_addr", acc_q[a], pc0 + 32'd4);
    lat_max = 3;
    wait_for(2, 32'd0, "c_wait");
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    n0 = n_iv;
    a = acc_q.size();
    wait_for(3, 32'(a + 1), "c_next_req");
    chk("c_redir_addr", acc_q[a], 32'h8000_0100);
    chk("c_dropped", 32'(n_iv - n0), 32'd0);
    lat_max = 0;
    irdy = 0;
    inst_ready = 1'b0;
    wait_for(0, 32'd0, "d_valid");
    irdy = 1;
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    a = acc_q.size();
    wait_for(3, 32'(a + 1), "d_next_req");
    chk("d_redir_addr", acc_q[a], 32'h8000_0200);
    irdy = 0;
    inst_ready = 1'b0;
    wait_for(0, 32'd0, "e_valid");
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0008;
    cycle();
    wait_for(1, 32'h8000_0008, "e_fault_inst");
    chk("e_fault", 32'(inst_fault), 32'd1);
    chk("e_ins", instruction, 32'h0000_0013);
    chk("e_pc", inst_pc, 32'h8000_0008);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    n0 = n_rqv;
    cycle();
    wait_for(1, 32'h8000_0102, "f_misaligned");
    chk("f_no_req", 32'(n_rqv - n0), 32'd0);
    chk("f_fault", 32'(inst_fault), 32'd1);
    chk("f_ins", instruction, 32'h0000_0013);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    irdy = 1;
    a = acc_q.size();
    wait_for(3, 32'(a + 2), "g_wrap");
    chk("g_top_addr", acc_q[a], 32'hFFFF_FFFC);
    chk("g_wrap_addr", acc_q[a+1], 32'h0000_0000);
    rd_rand = 1;
    rdy_rand = 1;
    irdy = 2;
    lat_fix = 0;
    lat_max = 4;
    repeat (4) begin
      repeat (1000) cycle();
      do_reset();
    end
    repeat (200) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
